// File: rtl/sm_display_pkg.sv
// rtl/sm_display_pkg.sv - shared types, widths and round-robin search for the display arbiter
package sm_display_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, SHOW} state_t;

  localparam int DIGIT_W = 4;
  localparam int VALUE_W = 12;
  localparam int DIGITS  = 3;
  localparam int MAX_SRC = 8;

  // Returns {found, index}; the search starts just after last, so the previous owner is tried last.
  function automatic logic [3:0] rr_search(input logic [MAX_SRC-1:0] req,
                                           input logic [2:0]         last,
                                           input int                 n_src);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      idx = 3'((int'(last) + k) % n_src);
      if (k <= n_src && !res[3] && req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/external_sm_btn_sync.sv
// rtl/external_sm_btn_sync.sv - 2-FF synchronizer with optional registered rising-edge pulse
module external_sm_btn_sync #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
    end
  end

  assign level = sync;

  generate
    if (EDGE_EN) begin : g_edge
      logic prev;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev <= 1'b0;
          rise <= 1'b0;
        end else begin
          prev <= sync;
          rise <= sync & ~prev;
        end
      end
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/external_sm_display_arbiter.sv
// rtl/external_sm_display_arbiter.sv - round-robin time-sharing of the 3-digit hex display
module external_sm_display_arbiter
  import sm_display_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26,
  localparam int IDX_W       = $clog2(N_SRC)
) (
  input  logic                   clkIn,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       req,
  input  logic [12*N_SRC-1:0]    value_flat,
  input  logic                   hold,
  input  logic                   next_btn,
  output logic [DIGIT_W-1:0]     digit_out_1,
  output logic [DIGIT_W-1:0]     digit_out_2,
  output logic [DIGIT_W-1:0]     digit_out_3,
  output logic [IDX_W-1:0]       src_idx,
  output logic [N_SRC-1:0]       grant,
  output logic                   display_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LEAVE = CNT_W'(DWELL_CYCLES - 2);

  state_t             state;
  logic [CNT_W-1:0]   dwell_cnt;
  logic [IDX_W-1:0]   last;
  logic               hold_sync;
  logic               next_pulse;
  logic               hold_rise_unused;
  logic               next_level_unused;
  logic [MAX_SRC-1:0] req_wide;
  logic [3:0]         pick;
  logic [VALUE_W-1:0] pick_value;

  external_sm_btn_sync #(.EDGE_EN(1'b0)) u_hold_sync (
    .clk      (clkIn),
    .rst_n    (rst_n),
    .async_in (hold),
    .level    (hold_sync),
    .rise     (hold_rise_unused)
  );

  external_sm_btn_sync #(.EDGE_EN(1'b1)) u_next_sync (
    .clk      (clkIn),
    .rst_n    (rst_n),
    .async_in (next_btn),
    .level    (next_level_unused),
    .rise     (next_pulse)
  );

  assign req_wide   = MAX_SRC'(req);
  assign pick       = rr_search(req_wide, 3'(last), N_SRC);
  assign pick_value = value_flat[VALUE_W*int'(pick[2:0]) +: VALUE_W];

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dwell_cnt     <= '0;
      last          <= IDX_W'(N_SRC - 1);
      digit_out_1   <= '0;
      digit_out_2   <= '0;
      digit_out_3   <= '0;
      src_idx       <= '0;
      grant         <= '0;
      display_valid <= 1'b0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          display_valid <= 1'b0;
          if (|req) state <= SCAN;
        end
        SCAN: begin
          if (pick[3]) begin
            digit_out_1   <= pick_value[DIGIT_W-1:0];
            digit_out_2   <= pick_value[2*DIGIT_W-1:DIGIT_W];
            digit_out_3   <= pick_value[3*DIGIT_W-1:2*DIGIT_W];
            src_idx       <= IDX_W'(pick[2:0]);
            grant         <= N_SRC'(1) << pick[2:0];
            display_valid <= 1'b1;
            last          <= IDX_W'(pick[2:0]);
            dwell_cnt     <= '0;
            state         <= SHOW;
          end else begin
            display_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        SHOW: begin
          if (dwell_cnt != CNT_MAX) dwell_cnt <= dwell_cnt + CNT_W'(1);
          // Leave on the edge where the counter reaches its last value, so each source gets exactly DWELL_CYCLES.
          if (next_pulse || (dwell_cnt >= CNT_LEAVE && !hold_sync)) state <= SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/external_sm_display_arbiter.md
# external_sm_display_arbiter

Time-shares the three-digit hex display among up to `N_SRC` requesters, each presenting a 12-bit value. Grants are round-robin with a fixed dwell time per source. Each source's value is snapshotted on grant and driven as three 4-bit digits into `external_sm_hex_display`. A user `hold` switch freezes rotation and a `next_btn` push skips to the next requester; the block sits between the CPU/debug sources and the display wrapper on the DE10 board.

## Interface
- `N_SRC`, 4: number of requesters, 2..8.
- `DWELL_CYCLES`, 50_000_000: cycles each source stays on display (1 s at 50 MHz); ≥4.
- `CNT_W`, 26: dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES.
- `clkIn` in 1: single clock; wire to CLOCK_50.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_SRC: per-source request level.
- `value_flat` in 12*N_SRC: source i value at bits [12i+11:12i].
- `hold` in 1: asynchronous switch; freezes rotation while high.
- `next_btn` in 1: asynchronous push button, active-high; a rising edge forces the next grant.
- `digit_out_1` out 4: displayed value bits [3:0], feeds `digit_in_1`.
- `digit_out_2` out 4: displayed value bits [7:4], feeds `digit_in_2`.
- `digit_out_3` out 4: displayed value bits [11:8], feeds `digit_in_3`.
- `src_idx` out $clog2(N_SRC): index of the source currently shown.
- `grant` out N_SRC: one-hot, one-cycle pulse marking the cycle a source's value is latched.
- `display_valid` out 1: high while a latched value is shown.

## Operation
- All outputs are registered. Reset values:
  - `digit_out_*` = 0, `src_idx` = 0, `grant` = 0, `display_valid` = 0.
  - State IDLE, dwell counter 0.
  - Last-grant pointer = N_SRC-1, so the first scan starts at source 0.
- `hold` and `next_btn` each pass through a 2-FF synchronizer. `next_btn` additionally has a third flop for rising-edge detection, producing a one-cycle `next_pulse`.
- IDLE: `display_valid` = 0 and digits are held at their last values (0 after reset). If any `req` bit is high, go to SCAN.
- SCAN (exactly 1 cycle): search `req` starting at last+1 and wrapping modulo N_SRC. The current owner is considered last, so it is re-granted only when it is the sole requester.
  - Found source j: latch `value_flat` slice j into the digits, set `src_idx` = j, pulse `grant[j]`, set `display_valid` = 1, last = j, clear the counter, go to SHOW.
  - None found: go to IDLE with `display_valid` = 0.
- SHOW: the counter increments each cycle and saturates at DWELL_CYCLES-1.
  - Leave for SCAN when the counter is at DWELL_CYCLES-1 and synchronized `hold` = 0.
  - Leave for SCAN immediately on `next_pulse`, regardless of `hold` or the counter.
- The owner deasserting `req` during SHOW does not blank the display; the snapshot stays until dwell expiry or `next_pulse`.
- Changes on `value_flat` after the grant are ignored until the next grant to that source.
- Simultaneous events:
  - `next_pulse` together with dwell expiry: a single SCAN.
  - `hold` rising in the expiry cycle: hold wins, the counter stays saturated, and SCAN follows on the first cycle after hold is released.
- `rst_n` low mid-operation immediately forces all reset values, independent of `clkIn`.

## Timing
- IDLE→display latency: for `req` first high at edge k, SCAN occupies cycle k..k+1. At edge k+1 the digits, `src_idx` and `display_valid` update and `grant` goes high for one cycle.
- Dwell: the new value first appears at edge g; the next SCAN is entered at edge g+DWELL_CYCLES-1 and the next value appears at edge g+DWELL_CYCLES. Each source is shown for exactly DWELL_CYCLES cycles.
- `next_btn` latency: for `next_btn` first sampled high at edge k, `next_pulse` is high in cycle k+2, SCAN is entered at k+3, and new digits appear at edge k+4.
- `hold` latency: 2 cycles through the synchronizer.
- No combinational paths from any input to any output.

## Structure
- Shared package `sm_display_pkg`:
  - state enum {IDLE, SCAN, SHOW}.
  - `DIGIT_W` = 4, `VALUE_W` = 12, `DIGITS` = 3.
- Sub-module `external_sm_btn_sync`: 2-FF synchronizer with optional rising-edge output. Instantiated twice: edge output used for `next_btn`, level output used for `hold`.
- Round-robin search is a combinational function in the package, parameterized by N_SRC.

## Test plan
Benches run with DWELL_CYCLES=8.
- Reset with `req`=0 → all outputs 0, `display_valid` 0. Then `req`=4'b0010, value1=12'hABC → `grant`=0010 one cycle after SCAN; digits 3/2/1 = A/B/C; `src_idx`=1.
- `req`=4'b1011 with distinct values → grant order 0,1,3,0,… Each shown exactly 8 cycles.
- Owner drops `req` mid-dwell and its `value_flat` changes → digits unchanged until expiry, then the next requester is shown. If none remains, `display_valid` falls one cycle after SCAN.
- `hold`=1 across expiry → no grant for 20 cycles. Release → new grant 3 cycles after `hold` falls (2 sync + SCAN).
- `next_btn` pulse at counter=2 while `hold`=1 → new digits exactly 4 edges after first sample. Same-edge `next_pulse` and expiry → a single grant.
- `rst_n` asserted mid-SHOW → outputs 0 asynchronously, before the next `clkIn` edge. After release, the scan restarts from source 0.
